// File: rtl/cla_shift_add_mult_seq_pkg.sv
// Shared types and constants for the shift-and-add multiplier built on the 16-bit cin adder.
// Also holds the carry-out reconstruction used by anyone driving that adder.
package cla_shift_add_mult_seq_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_ITERS = 16;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // The adder exposes no carry-out, so recover it from the operand and sum MSBs.
  function automatic logic cin_adder_cout(input logic a_msb, input logic b_msb, input logic sum_msb);
    return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum_msb);
  endfunction

endpackage

// File: rtl/alt_carry_look_ahead_adder_cin.sv
// 16-bit two-level carry-lookahead adder with carry-in and no carry-out port.
// Four 4-bit groups; group carries come from a flat lookahead over group generate/propagate.
module alt_carry_look_ahead_adder_cin (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum
);

  logic [14:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [2:0]  w_gg;
  logic [2:0]  w_gp;
  logic [3:0]  w_cg;

  assign w_g = i_a[14:0] & i_b[14:0];
  assign w_p = i_a ^ i_b;

  genvar gi, gk;

  // Only the lower three groups feed a carry into a higher group.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_grp_pg
      assign w_gg[gi] = w_g[4*gi+3]
                      | (w_p[4*gi+3] & w_g[4*gi+2])
                      | (w_p[4*gi+3] & w_p[4*gi+2] & w_g[4*gi+1])
                      | ((&w_p[4*gi+3:4*gi+1]) & w_g[4*gi]);
      assign w_gp[gi] = &w_p[4*gi+3:4*gi];
    end
  endgenerate

  assign w_cg[0] = i_cin;
  assign w_cg[1] = w_gg[0] | (w_gp[0] & i_cin);
  assign w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
  assign w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | ((&w_gp) & i_cin);

  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp_carry
      assign w_c[4*gi] = w_cg[gi];
      for (gk = 0; gk < 3; gk++) begin : g_bit
        assign w_c[4*gi+gk+1] = w_g[4*gi+gk] | (w_p[4*gi+gk] & w_c[4*gi+gk]);
      end
    end
  endgenerate

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/cla_shift_add_mult_seq.sv
// Unsigned 16x16->32 multiplier: one shared cin adder pass per multiplier bit,
// with valid/ready handshakes on request and result.
module cla_shift_add_mult_seq
  import cla_shift_add_mult_seq_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter bit ZERO_SHORTCUT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  generate
    if (WIDTH != MUL_WIDTH) begin : g_width_check
      $error("cla_shift_add_mult_seq: WIDTH must be 16 to match the adder");
    end
  endgenerate

  mul_state_t       r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_run;
  logic             w_zero_req;

  assign w_run      = (r_state == RUN);
  assign w_zero_req = ZERO_SHORTCUT && ((in_a == '0) || (in_b == '0));

  // Adder inputs are forced to zero outside RUN to keep the datapath quiet.
  assign w_add_a = w_run ? r_hi : '0;
  assign w_add_b = (w_run && r_lo[0]) ? r_m : '0;

  alt_carry_look_ahead_adder_cin u_adder (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (1'b0),
    .o_sum (w_sum)
  );

  assign w_cout = cin_adder_cout(w_add_a[WIDTH-1], w_add_b[WIDTH-1], w_sum[WIDTH-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_m   <= in_a;
            r_hi  <= '0;
            r_cnt <= '0;
            if (w_zero_req) begin
              r_lo    <= '0;
              r_state <= DONE;
            end else begin
              r_lo    <= in_b;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          // 33-bit right shift of {cout, sum, LO} into {HI, LO}.
          r_hi  <= {w_cout, w_sum[WIDTH-1:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(MUL_ITERS - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = w_run;
  assign out_valid = (r_state == DONE);
  assign out_p     = {r_hi, r_lo};

endmodule

// File: doc/cla_shift_add_mult_seq.md
Name: cla_shift_add_mult_seq

Overview:
- Multi-cycle unsigned 16x16 -> 32 multiplier sequencer.
- Time-shares one instance of the team's 16-bit carry-lookahead adder (alt_carry_look_ahead_adder_cin) using shift-and-add: one adder pass per multiplier bit.
- Sits beside the ALU as the MUL execution unit, with valid/ready handshakes on the request and result sides.

Parameters:
- WIDTH, 16, operand width. Fixed at 16 to match the adder; any other value is a compile-time error.
- ZERO_SHORTCUT, 1, when 1 a request with either operand zero completes without iterating.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready at a clk edge
- in_a  input  16  multiplicand
- in_b  input  16  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- out_p  output  32  product {hi, lo}
- busy  output  1  high while in RUN

Behaviour:
- Registers:
  - M: 16-bit multiplicand.
  - HI and LO: 16 bits each; LO initialised to the multiplier.
  - CNT: 5 bits.
  - state ∈ {IDLE, RUN, DONE}.
- Reset (async, any time, including mid-RUN):
  - state = IDLE; M, HI, LO, CNT = 0.
  - out_valid = 0, busy = 0, out_p = 0, in_ready = 1 once reset deasserts.
- in_ready = (state == IDLE). busy = (state == RUN). out_valid = (state == DONE). out_p = {HI, LO}.
- IDLE, on in_valid handshake at edge k: M = in_a; LO = in_b; HI = 0; CNT = 0.
  - If ZERO_SHORTCUT and (in_a == 0 or in_b == 0): HI = LO = 0, go to DONE. out_valid is high after edge k+1.
  - Otherwise go to RUN.
- RUN, each cycle:
  - Adder inputs: A = HI; B = LO[0] ? M : 0; cin = 0.
  - Carry-out derived from the adder result, because the adder has no cout port: cout = (A[15] & B[15]) | ((A[15] ^ B[15]) & ~R[15]).
  - Update: {HI, LO} <= {cout, R, LO[15:1]}, i.e. a 33-bit right shift. CNT <= CNT + 1.
  - When CNT == 15 on the current edge (the 16th iteration), go to DONE.
  - Normal latency: handshake at edge k, out_valid high after edge k+17.
- DONE: hold out_p stable while out_valid && !out_ready (arbitrary backpressure duration). On out handshake, go to IDLE.
- No same-cycle turnaround: a new request is accepted no earlier than the edge after the out handshake. Peak throughput is 1 product per 18 cycles.
- in_valid, in_a and in_b are ignored outside IDLE. Changing them during RUN must not affect the result.
- Outside RUN, the adder inputs are driven to 0 so the adder does not toggle.
- No overflow is possible: the 32-bit product of two 16-bit values always fits.
- The CNT wrap past 15 is unreachable; the RUN exit at 15 is mandatory.

Decomposition:
- Shared package holds:
  - state enum: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - MUL_WIDTH = 16.
  - MUL_ITERS = 16.
  - CNT_W = 5.
  - A carry-out helper function implementing the cout equation above, reusable by other users of the cin adder.
- Sub-module: one instance of alt_carry_look_ahead_adder_cin as the datapath.
- FSM, counter and shift registers live in cla_shift_add_mult_seq itself; no other sub-module.

Test Plan:
- Basic: a = 3, b = 5, out_ready = 1 -> out_p = 0x0000000F, out_valid rising exactly 17 cycles after accept, busy high for 16 cycles.
- Max: a = 0xFFFF, b = 0xFFFF -> out_p = 0xFFFE0001. Exercises cout on every iteration.
- Carry path: a = 0x8000, b = 0x0002 -> out_p = 0x00010000. Also check a = 0xFFFF, b = 0x0001 -> out_p = 0x0000FFFF.
- Zero shortcut: ZERO_SHORTCUT = 1, a = 0, b = 0x1234 -> out_p = 0, out_valid one cycle after accept, busy never high. With ZERO_SHORTCUT = 0 -> out_p = 0 after 17 cycles.
- Backpressure and no turnaround:
  - a = 0x1234, b = 0x5678 with out_ready low for 5 cycles in DONE -> out_p = 0x06260060 held constant, in_ready = 0 throughout.
  - A second request presented continuously is accepted on the edge after the out handshake.
  - Changing in_a during RUN has no effect.
- Reset mid-operation: assert reset asynchronously after the 8th RUN iteration -> out_valid, busy, out_p go to 0 immediately. After deassert, in_ready = 1, and the next request a = 7, b = 9 yields 0x0000003F.
